// File: rtl/sort_input_collector.sv
`default_nettype none
// ============================================================================
// Module   : sort_input_collector
// Brief    : Serial-to-parallel feeder for the insertion-sort engine. Collects
//            NUM_VALS elements (or fewer, padded, on i_last), pulses o_start,
//            then holds the frame until the sorter reports i_done.
// Revision : 1.0 - initial release
// ============================================================================
module sort_input_collector #(
  parameter int                   NUM_VALS  = 5,
  parameter int                   SIZE_DATA = 8,
  parameter logic [SIZE_DATA-1:0] PAD_VALUE = {SIZE_DATA{1'b1}}
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [SIZE_DATA-1:0]            i_data,
  input  logic                            i_last,
  output logic                            o_start,
  output logic [NUM_VALS*SIZE_DATA-1:0]   o_data,
  output logic [$clog2(NUM_VALS+1)-1:0]   o_count,
  input  logic                            i_done,
  output logic                            o_busy
);

  localparam int c_idx_w = $clog2(NUM_VALS + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_VALS - 1);
  localparam logic [c_idx_w-1:0] c_one      = c_idx_w'(1);

  localparam logic [1:0] c_collect   = 2'd0;
  localparam logic [1:0] c_launch    = 2'd1;
  localparam logic [1:0] c_wait_done = 2'd2;

  logic [1:0]                        r_state;
  logic [1:0]                        w_state_next;
  logic [c_idx_w-1:0]                r_idx;
  logic [c_idx_w-1:0]                r_count;
  logic [NUM_VALS*SIZE_DATA-1:0]     r_data;
  logic                              w_handshake;
  logic                              w_final;
  logic                              w_release;

  // Handshake qualifiers; o_ready depends on state only, so no input-to-ready path
  assign w_handshake = i_valid & o_ready;
  assign w_final     = w_handshake & ((r_idx == c_last_idx) | i_last);
  assign w_release   = i_done & ((r_state == c_launch) | (r_state == c_wait_done));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= c_collect;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; i_done is honoured in both LAUNCH and WAIT_DONE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_collect: begin
        if (w_final) begin
          w_state_next = c_launch;
        end
      end
      c_launch: begin
        w_state_next = i_done ? c_collect : c_wait_done;
      end
      c_wait_done: begin
        if (i_done) begin
          w_state_next = c_collect;
        end
      end
      default: begin
        w_state_next = c_collect;
      end
    endcase
  end

  // Output decode from state only
  always_comb begin
    o_ready = 1'b0;
    o_start = 1'b0;
    o_busy  = 1'b0;
    case (r_state)
      c_collect: begin
        o_ready = 1'b1;
      end
      c_launch: begin
        o_start = 1'b1;
        o_busy  = 1'b1;
      end
      c_wait_done: begin
        o_busy  = 1'b1;
      end
      default: begin
        o_ready = 1'b0;
      end
    endcase
  end

  // Datapath: slot write, same-cycle padding on the final handshake, index and count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      if (w_handshake) begin
        for (int k = 0; k < NUM_VALS; k++) begin
          if (c_idx_w'(k) == r_idx) begin
            r_data[k*SIZE_DATA +: SIZE_DATA] <= i_data;
          end else if (w_final && (c_idx_w'(k) > r_idx)) begin
            r_data[k*SIZE_DATA +: SIZE_DATA] <= PAD_VALUE;
          end
        end
        // idx holds on the final element; it is rewound when the sorter finishes
        if (w_final) begin
          r_count <= r_idx + c_one;
        end else begin
          r_idx <= r_idx + c_one;
        end
      end
      if (w_release) begin
        r_idx <= '0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule
`default_nettype wire
